// File: rtl/port_pkg.sv
// port_pkg: shared definitions for the switch-port read/write frontends.
//   DEPTH/AW        default FIFO depth and pointer width
//   hw_t            16-bit half-word
//   fifo_entry_t    buffered half-word plus its end-of-packet flag
//   LEN_MSB/LEN_LSB header length field position inside the first half-word
//   rd_state_t      egress FSM states
package port_pkg;
  localparam int DEPTH        = 64;
  localparam int AW           = 6;
  localparam int PAUSE_MARGIN = 2;
  localparam int LEN_MSB      = 15;
  localparam int LEN_LSB      = 7;

  typedef logic [15:0] hw_t;

  typedef struct packed {
    logic eop;
    hw_t  data;
  } fifo_entry_t;

  typedef enum logic [1:0] {IDLE, SOP, DATA, EOP} rd_state_t;
endpackage

// File: rtl/port_rd_fifo.sv
// port_rd_fifo: synchronous FIFO of fifo_entry_t with show-ahead head.
//   clk, rst_n   clock, async active-low reset (pointers/count only)
//   push, din    write request; ignored while full
//   pop, dout    read request; ignored while empty; dout is the current head
//   count        occupancy 0..DEPTH
//   full, empty  occupancy flags
module port_rd_fifo
  import port_pkg::*;
#(
  parameter int DEPTH = port_pkg::DEPTH,
  parameter int AW    = port_pkg::AW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t dout,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);
  fifo_entry_t       mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push_ok, pop_ok;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset: a reset only needs to forget the contents.
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;   // wraps naturally
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/port_rd_frontend.sv
// port_rd_frontend: egress frontend of one switch port.
// Buffers half-words from the SRAM backend and replays each packet as
// rd_sop -> rd_vld/rd_data beats -> rd_eop, checking the header length.
//   clk, rst_n                 clock, async active-low reset
//   xfer_data_vld/xfer_data    backend push, end_of_packet marks the last half-word
//   xfer_pause                 registered backpressure to the backend
//   ready                      external side can take a new packet (sampled in IDLE)
//   rd_sop/rd_vld/rd_data/rd_eop  outgoing packet
//   packet_amount              complete packets buffered
//   len_err                    pulse with rd_eop when beat count != header length
//   overflow                   sticky, push seen while full
// Build option: CUT_THROUGH_EN starts a packet on its first buffered half-word
// instead of waiting for the whole packet.
module port_rd_frontend
  import port_pkg::*;
#(
  parameter int DEPTH        = port_pkg::DEPTH,
  parameter int AW           = port_pkg::AW,
  parameter int PAUSE_MARGIN = port_pkg::PAUSE_MARGIN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        xfer_data_vld,
  input  logic [15:0] xfer_data,
  input  logic        end_of_packet,
  output logic        xfer_pause,
  input  logic        ready,
  output logic        rd_sop,
  output logic        rd_vld,
  output logic [15:0] rd_data,
  output logic        rd_eop,
  output logic [6:0]  packet_amount,
  output logic        len_err,
  output logic        overflow
);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] MARGIN_C = (AW+1)'(PAUSE_MARGIN);

  rd_state_t   state;
  fifo_entry_t head;
  logic [AW:0] count;
  logic        full, empty, pop, start_ok;
  logic        push_eop, pop_eop, mismatch, err_q;
  logic [8:0]  beat_cnt, cnt_next, hdr_len, hdr_now;

  port_rd_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (xfer_data_vld),
    .din   ({end_of_packet, xfer_data}),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef CUT_THROUGH_EN
  assign start_ok = ~empty;
`else
  assign start_ok = packet_amount != '0;
`endif

  assign pop      = ((state == SOP) || (state == DATA)) && !empty;
  assign push_eop = xfer_data_vld & end_of_packet & ~full;
  assign pop_eop  = pop & head.eop;
  assign cnt_next = beat_cnt + 9'd1;
  // The first pop carries the header, so compare against it directly
  // (covers single-beat packets whose header is also the eop entry).
  assign hdr_now  = (beat_cnt == '0) ? head.data[LEN_MSB:LEN_LSB] : hdr_len;
  assign mismatch = cnt_next != hdr_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_sop        <= 1'b0;
      rd_vld        <= 1'b0;
      rd_data       <= '0;
      rd_eop        <= 1'b0;
      len_err       <= 1'b0;
      err_q         <= 1'b0;
      overflow      <= 1'b0;
      xfer_pause    <= 1'b0;
      packet_amount <= '0;
      beat_cnt      <= '0;
      hdr_len       <= '0;
    end else begin
      rd_sop     <= 1'b0;
      rd_eop     <= 1'b0;
      len_err    <= 1'b0;
      rd_vld     <= pop;
      overflow   <= overflow | (xfer_data_vld & full);
      xfer_pause <= (DEPTH_C - count) <= MARGIN_C;

      case ({push_eop, pop_eop})
        2'b10:   packet_amount <= packet_amount + 7'd1;
        2'b01:   packet_amount <= packet_amount - 7'd1;
        default: packet_amount <= packet_amount;
      endcase

      if (pop) begin
        rd_data  <= head.data;
        beat_cnt <= cnt_next;
        if (beat_cnt == '0) hdr_len <= head.data[LEN_MSB:LEN_LSB];
        if (head.eop)       err_q   <= mismatch;
      end

      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (ready && start_ok) begin
            state  <= SOP;
            rd_sop <= 1'b1;
          end
        end
        SOP, DATA: state <= pop_eop ? EOP : DATA;
        EOP: begin
          rd_eop  <= 1'b1;
          len_err <= err_q;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_port_rd_frontend.sv
module tb_port_rd_frontend;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        xfer_data_vld, end_of_packet, ready;
  logic [15:0] xfer_data;
  logic        xfer_pause, rd_sop, rd_vld, rd_eop, len_err, overflow;
  logic [15:0] rd_data;
  logic [6:0]  packet_amount;

  int checks = 0, errors = 0;
  int cyc = 0, last_push_cyc = 0, stray = 0;
  int          sop_q[$], eop_q[$], beatc_q[$];
  logic [15:0] beat_q[$];
  logic        lerr_q[$];
  logic [6:0]  pa_q[$];
  logic [6:0]  pa_last = '0;

  port_rd_frontend dut (
    .clk(clk), .rst_n(rst_n), .xfer_data_vld(xfer_data_vld), .xfer_data(xfer_data),
    .end_of_packet(end_of_packet), .xfer_pause(xfer_pause), .ready(ready),
    .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_data(rd_data), .rd_eop(rd_eop),
    .packet_amount(packet_amount), .len_err(len_err), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (packet_amount != pa_last) begin
      pa_q.push_back(packet_amount);
      pa_last = packet_amount;
    end
    if (rst_n) begin
      if (rd_sop) sop_q.push_back(cyc);
      if (rd_vld) begin beat_q.push_back(rd_data); beatc_q.push_back(cyc); end
      if (rd_eop) begin eop_q.push_back(cyc); lerr_q.push_back(len_err); end
      if (len_err && !rd_eop) stray++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  task automatic clear_log();
    sop_q.delete(); eop_q.delete(); beatc_q.delete();
    beat_q.delete(); lerr_q.delete(); pa_q.delete(); stray = 0;
  endtask

  task automatic push(input logic [15:0] d, input logic e);
    xfer_data_vld = 1'b1; xfer_data = d; end_of_packet = e;
    @(posedge clk); #1;
    xfer_data_vld = 1'b0; end_of_packet = 1'b0;
    last_push_cyc = cyc;
  endtask

  // Header carries len in [15:7]; body beat i is base+i.
  task automatic push_pkt(input int len, input logic [15:0] base);
    push(16'(len << 7), len == 1);
    for (int i = 1; i < len; i++) push(base + 16'(i), i == len - 1);
  endtask

  task automatic wait_eop(input int n, input int budget);
    int t = 0;
    while (eop_q.size() < n && t < budget) begin @(posedge clk); t++; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; xfer_data_vld = 1'b0; xfer_data = '0; end_of_packet = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({rd_sop, rd_vld, rd_data, rd_eop, packet_amount, len_err, overflow, xfer_pause} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h exp 0",
        {rd_sop, rd_vld, rd_data, rd_eop, packet_amount, len_err, overflow, xfer_pause});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_packet();
    logic [15:0] exp_d [4] = '{16'h0200, 16'hA001, 16'hA002, 16'hA003};
    clear_log(); ready = 1'b1;
    push_pkt(4, 16'hA000);
    wait_eop(1, 50);
    checks++;
    if (eop_q.size() != 1 || sop_q.size() != 1 || beat_q.size() != 4) begin
      errors++; $display("FAIL t1_counts: got sop=%0d beats=%0d eop=%0d exp 1/4/1",
        sop_q.size(), beat_q.size(), eop_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beat_q[i] !== exp_d[i] || beatc_q[i] != sop_q[0] + 1 + i) begin
          errors++; $display("FAIL t1_beat%0d: got %h@%0d exp %h@%0d", i, beat_q[i],
            beatc_q[i], exp_d[i], sop_q[0] + 1 + i);
        end
      end
      checks++;
      if (eop_q[0] != sop_q[0] + 5) begin
        errors++; $display("FAIL t1_eop_time: got %0d exp %0d", eop_q[0], sop_q[0] + 5);
      end
      checks++;
      if (lerr_q[0] !== 1'b0 || stray != 0) begin
        errors++; $display("FAIL t1_len_err: got %b stray %0d exp 0", lerr_q[0], stray);
      end
    end
    checks++;
    if (packet_amount !== 7'd0) begin
      errors++; $display("FAIL t1_pkt_amount: got %0d exp 0", packet_amount);
    end
  endtask

  task automatic test_len_err();
    logic [15:0] exp_d [3] = '{16'h0280, 16'hB001, 16'hB002};
    clear_log(); ready = 1'b1;
    push(16'h0280, 1'b0); push(16'hB001, 1'b0); push(16'hB002, 1'b1);
    wait_eop(1, 50);
    checks++;
    if (eop_q.size() != 1 || sop_q.size() != 1 || beat_q.size() != 3) begin
      errors++; $display("FAIL t2_counts: got sop=%0d beats=%0d eop=%0d exp 1/3/1",
        sop_q.size(), beat_q.size(), eop_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (beat_q[i] !== exp_d[i]) begin
          errors++; $display("FAIL t2_beat%0d: got %h exp %h", i, beat_q[i], exp_d[i]);
        end
      end
      checks++;
      if (lerr_q[0] !== 1'b1 || stray != 0) begin
        errors++; $display("FAIL t2_len_err: got %b stray %0d exp 1 stray 0", lerr_q[0], stray);
      end
      checks++;
      if (eop_q[0] != sop_q[0] + 4) begin
        errors++; $display("FAIL t2_eop_time: got %0d exp %0d", eop_q[0], sop_q[0] + 4);
      end
    end
  endtask

  task automatic test_fill_overflow();
    clear_log(); ready = 1'b0;
    push(16'h2000, 1'b0);
    for (int i = 1; i <= 60; i++) push(16'(i), 1'b0);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (xfer_pause !== 1'b0) begin
      errors++; $display("FAIL t3_pause_61: got %b exp 0", xfer_pause);
    end
    push(16'd61, 1'b0);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (xfer_pause !== 1'b1) begin
      errors++; $display("FAIL t3_pause_62: got %b exp 1", xfer_pause);
    end
    push(16'd62, 1'b0);
    push(16'd63, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL t3_no_overflow: got %b exp 0", overflow);
    end
    push(16'hDEAD, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (overflow !== 1'b1 || packet_amount !== 7'd1) begin
      errors++; $display("FAIL t3_overflow: got ovf=%b pkts=%0d exp 1/1", overflow, packet_amount);
    end
    ready = 1'b1;
    wait_eop(1, 200);
    checks++;
    if (beat_q.size() != 64 || eop_q.size() != 1) begin
      errors++; $display("FAIL t3_drain: got beats=%0d eop=%0d exp 64/1", beat_q.size(), eop_q.size());
    end else begin
      checks++;
      if (beat_q[0] !== 16'h2000 || beat_q[63] !== 16'd63 || lerr_q[0] !== 1'b0) begin
        errors++; $display("FAIL t3_data: got %h..%h err=%b exp 2000..003f err=0",
          beat_q[0], beat_q[63], lerr_q[0]);
      end
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (xfer_pause !== 1'b0 || packet_amount !== 7'd0) begin
      errors++; $display("FAIL t3_after: got pause=%b pkts=%0d exp 0/0", xfer_pause, packet_amount);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [4] = '{16'h0100, 16'h1111, 16'h0100, 16'h2222};
    ready = 1'b0;
    push(16'h0100, 1'b0); push(16'h1111, 1'b1);
    push(16'h0100, 1'b0); push(16'h2222, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (packet_amount !== 7'd2) begin
      errors++; $display("FAIL t4_pkts_2: got %0d exp 2", packet_amount);
    end
    clear_log(); ready = 1'b1;
    wait_eop(2, 50);
    checks++;
    if (pa_q.size() != 2 || eop_q.size() != 2 || sop_q.size() != 2 || beat_q.size() != 4) begin
      errors++; $display("FAIL t4_counts: got pa=%0d sop=%0d eop=%0d beats=%0d exp 2/2/2/4",
        pa_q.size(), sop_q.size(), eop_q.size(), beat_q.size());
    end else begin
      checks++;
      if (pa_q[0] !== 7'd1 || pa_q[1] !== 7'd0) begin
        errors++; $display("FAIL t4_pkts_seq: got %0d,%0d exp 1,0", pa_q[0], pa_q[1]);
      end
      checks++;
      if (sop_q[1] != eop_q[0] + 1) begin
        errors++; $display("FAIL t4_gap: got %0d exp %0d", sop_q[1], eop_q[0] + 1);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beat_q[i] !== exp_d[i]) begin
          errors++; $display("FAIL t4_beat%0d: got %h exp %h", i, beat_q[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    int t = 0;
    clear_log(); ready = 1'b1;
    push_pkt(4, 16'hC000);
    while (beat_q.size() < 2 && t < 50) begin @(posedge clk); t++; end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_sop, rd_vld, rd_data, rd_eop, packet_amount, len_err, overflow, xfer_pause} !== '0) begin
      errors++; $display("FAIL t5_async_reset: got %h exp 0",
        {rd_sop, rd_vld, rd_data, rd_eop, packet_amount, len_err, overflow, xfer_pause});
    end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_log();
    push_pkt(40, 16'h4000);
    wait_eop(1, 100);
    checks++;
    if (beat_q.size() != 40 || eop_q.size() != 1) begin
      errors++; $display("FAIL t5_pkt_a: got beats=%0d eop=%0d exp 40/1", beat_q.size(), eop_q.size());
    end
    clear_log();
    push_pkt(30, 16'h5000);   // write pointer wraps past 63 here
    wait_eop(1, 100);
    checks++;
    if (beat_q.size() != 30 || eop_q.size() != 1 || sop_q.size() != 1) begin
      errors++; $display("FAIL t5_pkt_b: got beats=%0d eop=%0d exp 30/1", beat_q.size(), eop_q.size());
    end else begin
      for (int i = 0; i < 30; i++) begin
        checks++;
        if (beat_q[i] !== ((i == 0) ? 16'h0F00 : 16'h5000 + 16'(i))) begin
          errors++; $display("FAIL t5_beat%0d: got %h exp %h", i, beat_q[i],
            (i == 0) ? 16'h0F00 : 16'h5000 + 16'(i));
        end
      end
      checks++;
      if (eop_q[0] != sop_q[0] + 31 || lerr_q[0] !== 1'b0) begin
        errors++; $display("FAIL t5_eop: got %0d err=%b exp %0d err=0", eop_q[0], lerr_q[0], sop_q[0] + 31);
      end
    end
  endtask

  // Packet whose body arrives late: store-and-forward waits for it,
  // cut-through starts early and gaps rd_vld.
  task automatic test_partial_packet();
    logic [15:0] exp_d [3] = '{16'h0180, 16'hD001, 16'hD002};
    clear_log(); ready = 1'b1;
    push(16'h0180, 1'b0);
    repeat (3) @(posedge clk); #1;
    push(16'hD001, 1'b0); push(16'hD002, 1'b1);
    wait_eop(1, 50);
    checks++;
    if (beat_q.size() != 3 || sop_q.size() != 1 || eop_q.size() != 1) begin
      errors++; $display("FAIL t6_counts: got sop=%0d beats=%0d eop=%0d exp 1/3/1",
        sop_q.size(), beat_q.size(), eop_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (beat_q[i] !== exp_d[i]) begin
          errors++; $display("FAIL t6_beat%0d: got %h exp %h", i, beat_q[i], exp_d[i]);
        end
      end
      checks++;
      if (lerr_q[0] !== 1'b0) begin
        errors++; $display("FAIL t6_len_err: got %b exp 0", lerr_q[0]);
      end
`ifdef CUT_THROUGH_EN
      checks++;
      if (!(sop_q[0] < last_push_cyc) || beatc_q[1] - beatc_q[0] < 3) begin
        errors++; $display("FAIL t6_cut_through: got sop=%0d eop_push=%0d gap=%0d exp sop<push gap>=3",
          sop_q[0], last_push_cyc, beatc_q[1] - beatc_q[0]);
      end
`else
      checks++;
      if (!(sop_q[0] > last_push_cyc) || beatc_q[2] - beatc_q[0] != 2) begin
        errors++; $display("FAIL t6_store_fwd: got sop=%0d eop_push=%0d span=%0d exp sop>push span=2",
          sop_q[0], last_push_cyc, beatc_q[2] - beatc_q[0]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_len_err();
    test_fill_overflow();
    test_back_to_back();
    test_reset_mid_packet();
    test_partial_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
